or1200_enc_pad_mgr: RTL

OR1200_ENC_PAD_MGR -- requirements
Module: or1200_enc_pad_mgr

---
 rtl/or1200_enc_pkg.sv | 20 ++
 rtl/or1200_enc_pad_chan.sv | 133 +++++++++++++
 rtl/or1200_enc_pad_mgr.sv | 120 ++++++++++++
 3 files changed

// File: rtl/or1200_enc_pkg.sv
// Shared definitions for the encrypted-pad manager.
// Purpose : default geometry, default AES key and the per-channel state
//           encoding used by or1200_enc_pad_chan and or1200_enc_pad_mgr.
// Ports   : none (package).
package or1200_enc_pkg;

    localparam int NCH_DEF    = 2;
    localparam int PAD_W_DEF  = 128;
    localparam int WORD_W_DEF = 32;

    localparam logic [127:0] KEY_DEF = 128'h202122232425262728292a2b2c2d2e2f;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,  // never seeded (or reset)
        CH_SEED = 2'd1,  // waiting for AES(seed)  -> cur
        CH_PREF = 2'd2,  // waiting for AES(cur)   -> next
        CH_RUN  = 2'd3   // streaming; refills next whenever it is empty
    } chan_state_e;

endpackage

// File: rtl/or1200_enc_pad_chan.sv
// One OFB pad channel.
// Purpose : holds the current and next pad blocks, the word pointer and a
//           1-bit generation tag; asks the shared AES engine for work and
//           hands out one pad word per accepted use.
// Ports   : clk, rst         - clock, synchronous active-high reset
//           seed_valid, seed - load a new seed (any state)
//           use_req          - consume one pad word this cycle
//           pad_word, stall  - current word / word not available
//           req, req_data    - AES work wanted and its plaintext
//           tag              - current generation tag
//           done, result     - AES result owned by this generation
module or1200_enc_pad_chan
    import or1200_enc_pkg::*;
#(
    parameter int PAD_W  = PAD_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    input  logic [PAD_W-1:0]  seed,
    input  logic              use_req,
    output logic [WORD_W-1:0] pad_word,
    output logic              stall,
    output logic              req,
    output logic [PAD_W-1:0]  req_data,
    output logic              tag,
    input  logic              done,
    input  logic [PAD_W-1:0]  result
);

    localparam int NWORD = PAD_W / WORD_W;
    localparam int WP_W  = (NWORD > 1) ? $clog2(NWORD) : 1;
    localparam logic [WP_W-1:0] WP_LAST = WP_W'(NWORD - 1);

    chan_state_e       state, state_nxt;
    logic [PAD_W-1:0]  seed_q;
    logic [PAD_W-1:0]  cur;
    logic [PAD_W-1:0]  nxt_pad;
    logic [WP_W-1:0]   wp;
    logic              cur_v;
    logic              next_v;
    logic              gen;
    logic              at_last;
    logic              accept;

    assign at_last  = (wp == WP_LAST);
    // The last word may only go out if the following block is already here,
    // because accepting it promotes next into cur.
    assign stall    = use_req && (rst || !cur_v || (at_last && !next_v));
    assign accept   = use_req && !stall;
    assign pad_word = (cur_v && !rst) ? cur[int'(wp)*WORD_W +: WORD_W] : '0;
    assign tag      = gen;

    // NOTE: every output of this block gets a default before the case, so
    // no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        req_data  = cur;
        unique case (state)
            CH_IDLE: ;
            CH_SEED: begin
                req      = 1'b1;
                req_data = seed_q;
                if (done) state_nxt = CH_PREF;
            end
            CH_PREF: begin
                req = 1'b1;
                if (done) state_nxt = CH_RUN;
            end
            CH_RUN: begin
                // OFB: next block is always AES of the block now in cur.
                req = !next_v;
            end
            default: state_nxt = CH_IDLE;
        endcase
        if (seed_valid) state_nxt = CH_SEED;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CH_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_v  <= 1'b0;
            next_v <= 1'b0;
            wp     <= '0;
            gen    <= 1'b0;
        end else if (seed_valid) begin
            cur_v  <= 1'b0;
            next_v <= 1'b0;
            wp     <= '0;
            gen    <= ~gen;
        end else begin
            if (done && state == CH_SEED) begin
                cur_v <= 1'b1;
            end else if (done && state != CH_IDLE) begin
                next_v <= 1'b1;
            end
            // A wrap needs next_v=1 while a refill result only arrives with
            // next_v=0, so the two never collide on next_v.
            if (accept) begin
                if (at_last) begin
                    wp     <= '0;
                    next_v <= 1'b0;
                end else begin
                    wp <= wp + WP_W'(1);
                end
            end
        end
    end

    // NOTE: pad and seed registers carry no reset; cur_v/next_v gate every
    // use of them, so clearing the flags is enough.
    always_ff @(posedge clk) begin
        if (seed_valid) seed_q <= seed;
        if (done && state == CH_SEED) begin
            cur <= result;
        end else if (accept && at_last) begin
            cur <= nxt_pad;
        end
        if (done && (state == CH_PREF || state == CH_RUN)) nxt_pad <= result;
    end

endmodule

// File: rtl/or1200_enc_pad_mgr.sv
// Encrypted-pad manager.
// Purpose : NCH independent OFB pad channels sharing one AES engine through
//           a round-robin arbiter with a single outstanding request.
// Ports   : clk, rst                      - clock, synchronous active-high reset
//           seed_valid_i/seed_ch_i/seed_i - seed a channel
//           use_req_i                     - per-channel word consume request
//           pad_word_o, stall_o           - per-channel pad word / stall
//           aes_req_o, aes_in_o, aes_key_o - AES start pulse, plaintext, key
//           aes_done_i, aes_out_i         - AES result pulse and ciphertext
module or1200_enc_pad_mgr
    import or1200_enc_pkg::*;
#(
    parameter int              NCH    = NCH_DEF,
    parameter int              PAD_W  = PAD_W_DEF,
    parameter int              WORD_W = WORD_W_DEF,
    parameter logic [PAD_W-1:0] KEY   = KEY_DEF,
    localparam int             CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_valid_i,
    input  logic [CH_W-1:0]       seed_ch_i,
    input  logic [PAD_W-1:0]      seed_i,
    input  logic [NCH-1:0]        use_req_i,
    output logic [NCH*WORD_W-1:0] pad_word_o,
    output logic [NCH-1:0]        stall_o,
    output logic                  aes_req_o,
    output logic [PAD_W-1:0]      aes_in_o,
    output logic [PAD_W-1:0]      aes_key_o,
    input  logic                  aes_done_i,
    input  logic [PAD_W-1:0]      aes_out_i
);

    logic [NCH-1:0]   chan_req;
    logic [NCH-1:0]   chan_tag;
    logic [NCH-1:0]   chan_done;
    logic [PAD_W-1:0] chan_data [NCH];

    logic             busy;
    logic [CH_W-1:0]  owner;
    logic             owner_tag;
    logic [CH_W-1:0]  rr_ptr;
    logic [PAD_W-1:0] in_q;
    logic             grant;
    logic [CH_W-1:0]  grant_idx;
    logic             deliver;

    assign aes_key_o = KEY;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        or1200_enc_pad_chan #(
            .PAD_W  (PAD_W),
            .WORD_W (WORD_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .seed_valid (seed_valid_i && seed_ch_i == CH_W'(i)),
            .seed       (seed_i),
            .use_req    (use_req_i[i]),
            .pad_word   (pad_word_o[i*WORD_W +: WORD_W]),
            .stall      (stall_o[i]),
            .req        (chan_req[i]),
            .req_data   (chan_data[i]),
            .tag        (chan_tag[i]),
            .done       (chan_done[i]),
            .result     (aes_out_i)
        );
        assign chan_done[i] = deliver && (owner == CH_W'(i));
    end

    // Round-robin: search starts at rr_ptr, the channel after the last grant.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = 1'b0;
        grant_idx = rr_ptr;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr_ptr) + k) % NCH;
            if (!grant && chan_req[idx]) begin
                grant     = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
        if (busy || rst) grant = 1'b0;
    end

    // A result belongs to the owner only if it was not reseeded meanwhile;
    // stale results just free the engine.
    assign deliver   = busy && aes_done_i && !rst && (chan_tag[owner] == owner_tag);
    assign aes_req_o = grant;

    always_comb begin
        aes_in_o = '0;
        if (!rst) begin
            if (busy)       aes_in_o = in_q;
            else if (grant) aes_in_o = chan_data[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            owner     <= '0;
            owner_tag <= 1'b0;
            rr_ptr    <= '0;
        end else if (busy) begin
            if (aes_done_i) busy <= 1'b0;
        end else if (grant) begin
            busy      <= 1'b1;
            owner     <= grant_idx;
            owner_tag <= chan_tag[grant_idx];
            rr_ptr    <= (grant_idx == CH_W'(NCH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!busy && grant) in_q <= chan_data[grant_idx];
    end

endmodule
